spell_sequencer: RTL and testbench
==================================

Name: spell_sequencer

Overview:
- Control FSM that drives the SPELL opcode execute datapath: fetches opcodes, feeds it operands, commits its results.
- Owns PC, SP and a 32-entry 8-bit stack.
- Issues reads and writes on a single shared code/data memory port.
- Handles delay, sleep, stop and host-injected (out-of-order) opcodes.

Parameters:
- DELAY_CYCLES, 256, clock cycles per unit of delay_amount (must be >=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- run  in  1  level; 1 = execute program from pc
- wake  in  1  one-cycle pulse; ends SLEEP
- inj_valid  in  1  host-injected opcode request (accepted in IDLE only)
- inj_opcode  in  8  injected opcode
- inj_ready  out  1  high in IDLE; inj_valid&inj_ready = accept
- mem_addr  out  8  memory address
- mem_rd  out  1  read strobe; data valid on mem_rdata next cycle
- mem_wr  out  1  write strobe, one cycle
- mem_space  out  2  MemoryTypeCode / MemoryTypeData (MemoryTypeNone when idle)
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data
- ex_opcode, ex_pc, ex_stack_top, ex_stack_belowtop, ex_memory_input  out  8  operands to execute datapath
- ex_sp  out  5  to datapath
- ex_out_of_order  out  1  to datapath
- ex_next_pc  in  8, ex_next_sp  in  5, ex_stack_write_count  in  2, ex_set_stack_top / ex_set_stack_belowtop  in  8, ex_mem_write_data / ex_mem_write_addr  in  8, ex_mem_write_type  in  2, ex_delay_amount  in  8, ex_sleep / ex_stop  in  1  datapath results
- pc  out  8, sp  out  5  architectural state
- busy  out  1  state != IDLE
- halted  out  1  high in HALT

Behaviour:
- Reset (async, rst_n=0):
  - pc=0, sp=0, stack contents don't-care, state=IDLE.
  - All strobes 0, mem_space=None, busy=0, halted=0, inj_ready=1.
- Stack convention:
  - top=stack[sp-1], belowtop=stack[sp-2]; indices mod 32; wrap silently on over/underflow.
  - ex_stack_top/belowtop are combinational reads.
- States: IDLE, FETCH, DECODE, MEMRD, EXEC, DELAY, SLEEP, HALT.
- IDLE:
  - Injection takes priority: inj_valid -> latch inj_opcode, set oo flag -> EXEC.
  - Else run=1 -> FETCH.
- FETCH: mem_rd=1, mem_space=Code, mem_addr=pc -> DECODE.
- DECODE: latch opcode=mem_rdata.
  - Opcode "?" -> MEMRD, reading Code at top.
  - Opcode "r" -> MEMRD, reading Data at top.
  - Otherwise -> EXEC.
- MEMRD: previous cycle issued the read; latch memory_input=mem_rdata -> EXEC.
  - For "?"/"r" the read is issued on DECODE->MEMRD, so two cycles total.
- EXEC: single commit cycle.
  - pc<=ex_next_pc, sp<=ex_next_sp.
  - stack_write_count>=1: stack[ex_next_sp-1]<=set_stack_top.
  - stack_write_count=2: additionally stack[ex_next_sp-2]<=set_stack_belowtop.
  - ex_mem_write_type!=None: mem_wr=1 same cycle; addr/data/space from datapath.
  - Next state, in priority order:
    - ex_stop -> HALT.
    - ex_sleep -> SLEEP.
    - delay_amount!=0 -> DELAY.
    - oo flag -> IDLE (clear oo).
    - run=1 -> FETCH.
    - else -> IDLE.
- DELAY: 16-bit-plus counter loaded with delay_amount*DELAY_CYCLES-1; counts to 0, then next state chosen as in EXEC (minus stop/sleep).
- SLEEP: wait for wake; then as DELAY exit. wake outside SLEEP ignored.
- HALT: halted=1; exit to IDLE only when run=0. pc not advanced by 0xFF (next_pc already applied).
- run=0 mid-program: the current instruction completes; return to IDLE at the next instruction boundary.
- Throughput:
  - Normal opcode: 3 cycles (FETCH, DECODE, EXEC).
  - "?"/"r": 4 cycles.
- Reset mid-operation aborts immediately; no partial memory write is completed.

Optional Feature:
- SPELL_SINGLE_STEP_EN:
  - Adds input step (1-cycle pulse) and output step_mode.
  - While run=0 and step=1 in IDLE: execute exactly one fetched instruction, then return to IDLE.
  - Injection still has priority over step.
- Without the macro: no step port; run is the only way to fetch.

Test Plan:
- Code[0..2]="7","3","+", code[3]=0xFF; run=1 -> after EXEC of "+" stack[0]=0x6A ("7"+"3"=0x37+0x33), sp=1; HALT with pc=4; halted=1 until run=0.
- Push 0x05, push 0x10, "w" -> mem_wr=1, mem_space=Data, mem_addr=0x10, mem_wdata=0x05, sp=0.
- "," with top=2, DELAY_CYCLES=4 -> exactly 8 cycles in DELAY before next FETCH.
- "z" -> SLEEP held 50 cycles with no change; wake pulse -> next FETCH at pc+1.
- IDLE, inj_valid=1, inj_opcode="A" -> ex_out_of_order=1, stack[0]=0x41, sp=1, pc unchanged, returns to IDLE.
- Stack wrap: sp=31, push "B" -> stack[31]=0x42, sp=0; assert rst_n low during DELAY -> immediate IDLE, pc=0, no strobes.

Source files
------------

// File: rtl/spell_sequencer.sv
// Control sequencer for the SPELL execute datapath: fetch/decode/commit, PC/SP/stack ownership, delay/sleep/halt.
// Optional SPELL_SINGLE_STEP_EN adds a step pulse input and step_mode output for single-instruction execution.
module spell_sequencer #(
    parameter int unsigned DELAY_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       wake,
    input  logic       inj_valid,
    input  logic [7:0] inj_opcode,
    output logic       inj_ready,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] mem_space,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [7:0] ex_opcode,
    output logic [7:0] ex_pc,
    output logic [7:0] ex_stack_top,
    output logic [7:0] ex_stack_belowtop,
    output logic [7:0] ex_memory_input,
    output logic [4:0] ex_sp,
    output logic       ex_out_of_order,
    input  logic [7:0] ex_next_pc,
    input  logic [4:0] ex_next_sp,
    input  logic [1:0] ex_stack_write_count,
    input  logic [7:0] ex_set_stack_top,
    input  logic [7:0] ex_set_stack_belowtop,
    input  logic [7:0] ex_mem_write_data,
    input  logic [7:0] ex_mem_write_addr,
    input  logic [1:0] ex_mem_write_type,
    input  logic [7:0] ex_delay_amount,
    input  logic       ex_sleep,
    input  logic       ex_stop,
    output logic [7:0] pc,
    output logic [4:0] sp,
    output logic       busy,
`ifdef SPELL_SINGLE_STEP_EN
    input  logic       step,
    output logic       step_mode,
`endif
    output logic       halted
);

    localparam int unsigned STACK_DEPTH = 32;
    localparam int unsigned CNT_W       = 8 + $clog2(DELAY_CYCLES) + 1;
    localparam logic [1:0]  MEM_NONE    = 2'd0;
    localparam logic [1:0]  MEM_CODE    = 2'd1;
    localparam logic [1:0]  MEM_DATA    = 2'd2;
    localparam logic [7:0]  OP_CODE_RD  = 8'h3F;  // "?"
    localparam logic [7:0]  OP_DATA_RD  = 8'h72;  // "r"

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_EXEC, S_DELAY, S_SLEEP, S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic [4:0]         sp_q, sp_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [7:0]         minput_q, minput_d;
    logic               oo_q, oo_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         stack_q [STACK_DEPTH];
    logic               we_top, we_below;
    logic               resume_fetch;
    state_e             resume_state;

    assign ex_stack_top      = stack_q[sp_q - 5'd1];
    assign ex_stack_belowtop = stack_q[sp_q - 5'd2];
    assign ex_opcode         = opcode_q;
    assign ex_pc             = pc_q;
    assign ex_sp             = sp_q;
    assign ex_memory_input   = minput_q;
    assign ex_out_of_order   = oo_q;
    assign pc                = pc_q;
    assign sp                = sp_q;
    assign busy              = (state_q != S_IDLE);
    assign halted            = (state_q == S_HALT);
    assign inj_ready         = (state_q == S_IDLE);
`ifdef SPELL_SINGLE_STEP_EN
    assign step_mode         = step_q;
`endif

    // Instruction boundary: injected or single-stepped work always returns to IDLE.
    assign resume_fetch = run && !oo_q && !step_q;
    assign resume_state = resume_fetch ? S_FETCH : S_IDLE;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        sp_d      = sp_q;
        opcode_d  = opcode_q;
        minput_d  = minput_q;
        oo_d      = oo_q;
        step_d    = step_q;
        cnt_d     = cnt_q;
        we_top    = 1'b0;
        we_below  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_space = MEM_NONE;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;

        unique case (state_q)
            S_IDLE: begin
                if (inj_valid) begin
                    opcode_d = inj_opcode;
                    oo_d     = 1'b1;
                    state_d  = S_EXEC;
                end else if (run) begin
                    state_d = S_FETCH;
                end
`ifdef SPELL_SINGLE_STEP_EN
                else if (step) begin
                    step_d  = 1'b1;
                    state_d = S_FETCH;
                end
`endif
            end
            S_FETCH: begin
                mem_rd    = 1'b1;
                mem_space = MEM_CODE;
                mem_addr  = pc_q;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = mem_rdata;
                if (mem_rdata == OP_CODE_RD || mem_rdata == OP_DATA_RD) begin
                    mem_rd    = 1'b1;
                    mem_space = (mem_rdata == OP_CODE_RD) ? MEM_CODE : MEM_DATA;
                    mem_addr  = ex_stack_top;
                    state_d   = S_MEMRD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MEMRD: begin
                minput_d = mem_rdata;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                pc_d     = ex_next_pc;
                sp_d     = ex_next_sp;
                we_top   = (ex_stack_write_count != 2'd0);
                we_below = (ex_stack_write_count == 2'd2);
                if (ex_mem_write_type != MEM_NONE) begin
                    mem_wr    = 1'b1;
                    mem_space = ex_mem_write_type;
                    mem_addr  = ex_mem_write_addr;
                    mem_wdata = ex_mem_write_data;
                end
                if (ex_stop) begin
                    state_d = S_HALT;
                end else if (ex_sleep) begin
                    state_d = S_SLEEP;
                end else if (ex_delay_amount != 8'd0) begin
                    cnt_d   = CNT_W'(ex_delay_amount) * CNT_W'(DELAY_CYCLES) - CNT_W'(1);
                    state_d = S_DELAY;
                end else begin
                    state_d = resume_state;
                end
            end
            S_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = resume_state;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SLEEP: begin
                if (wake) begin
                    state_d = resume_state;
                end
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            oo_d   = 1'b0;
            step_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= 8'd0;
            sp_q     <= 5'd0;
            opcode_q <= 8'd0;
            minput_q <= 8'd0;
            oo_q     <= 1'b0;
            step_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            opcode_q <= opcode_d;
            minput_q <= minput_d;
            oo_q     <= oo_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        if (we_top) begin
            stack_q[ex_next_sp - 5'd1] <= ex_set_stack_top;
        end
        if (we_below) begin
            stack_q[ex_next_sp - 5'd2] <= ex_set_stack_belowtop;
        end
    end

endmodule

// File: tb/tb_spell_sequencer.sv
// Directed bench for spell_sequencer with a small SPELL datapath model and code/data memory.
module tb_spell_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, run, wake, inj_valid;
    logic [7:0] inj_opcode;
    logic       inj_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_rd, mem_wr;
    logic [1:0] mem_space;
    logic [7:0] ex_opcode, ex_pc, ex_stack_top, ex_stack_belowtop, ex_memory_input;
    logic [4:0] ex_sp;
    logic       ex_out_of_order;
    logic [7:0] ex_next_pc;
    logic [4:0] ex_next_sp;
    logic [1:0] ex_stack_write_count;
    logic [7:0] ex_set_stack_top, ex_set_stack_belowtop;
    logic [7:0] ex_mem_write_data, ex_mem_write_addr;
    logic [1:0] ex_mem_write_type;
    logic [7:0] ex_delay_amount;
    logic       ex_sleep, ex_stop;
    logic [7:0] pc;
    logic [4:0] sp;
    logic       busy, halted;

    logic [7:0] cmem [256];
    logic [7:0] dmem [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         fcnt     = 0;
    int         ftime [16];
    int         faddr [16];
    int         wr_cnt   = 0;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] wr_space;
    logic       seen_oo  = 1'b0;

    spell_sequencer #(.DELAY_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .wake(wake),
        .inj_valid(inj_valid), .inj_opcode(inj_opcode), .inj_ready(inj_ready),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_space(mem_space),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ex_opcode(ex_opcode), .ex_pc(ex_pc), .ex_stack_top(ex_stack_top),
        .ex_stack_belowtop(ex_stack_belowtop), .ex_memory_input(ex_memory_input),
        .ex_sp(ex_sp), .ex_out_of_order(ex_out_of_order),
        .ex_next_pc(ex_next_pc), .ex_next_sp(ex_next_sp),
        .ex_stack_write_count(ex_stack_write_count),
        .ex_set_stack_top(ex_set_stack_top), .ex_set_stack_belowtop(ex_set_stack_belowtop),
        .ex_mem_write_data(ex_mem_write_data), .ex_mem_write_addr(ex_mem_write_addr),
        .ex_mem_write_type(ex_mem_write_type), .ex_delay_amount(ex_delay_amount),
        .ex_sleep(ex_sleep), .ex_stop(ex_stop),
        .pc(pc), .sp(sp), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    // Minimal SPELL datapath: unknown opcodes push themselves.
    always_comb begin
        ex_next_pc            = ex_out_of_order ? ex_pc : ex_pc + 8'd1;
        ex_next_sp            = ex_sp + 5'd1;
        ex_stack_write_count  = 2'd1;
        ex_set_stack_top      = ex_opcode;
        ex_set_stack_belowtop = 8'd0;
        ex_mem_write_data     = 8'd0;
        ex_mem_write_addr     = 8'd0;
        ex_mem_write_type     = 2'd0;
        ex_delay_amount       = 8'd0;
        ex_sleep              = 1'b0;
        ex_stop               = 1'b0;
        case (ex_opcode)
            8'h2B: begin
                ex_next_sp       = ex_sp - 5'd1;
                ex_set_stack_top = ex_stack_top + ex_stack_belowtop;
            end
            8'h77: begin
                ex_next_sp           = ex_sp - 5'd2;
                ex_stack_write_count = 2'd0;
                ex_mem_write_type    = 2'd2;
                ex_mem_write_addr    = ex_stack_top;
                ex_mem_write_data    = ex_stack_belowtop;
            end
            8'h2C: begin
                ex_next_sp           = ex_sp - 5'd1;
                ex_stack_write_count = 2'd0;
                ex_delay_amount      = ex_stack_top;
            end
            8'h7A: begin
                ex_next_sp           = ex_sp;
                ex_stack_write_count = 2'd0;
                ex_sleep             = 1'b1;
            end
            8'h3F, 8'h72: begin
                ex_next_sp       = ex_sp;
                ex_set_stack_top = ex_memory_input;
            end
            8'hFF: begin
                ex_next_sp           = ex_sp;
                ex_stack_write_count = 2'd0;
                ex_stop              = 1'b1;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= (mem_space == 2'd2) ? dmem[mem_addr] : cmem[mem_addr];
        if (mem_wr && mem_space == 2'd2) dmem[mem_addr] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_space == 2'd1 && mem_addr == pc && fcnt < 16) begin
            ftime[fcnt] = cyc;
            faddr[fcnt] = int'(mem_addr);
            fcnt = fcnt + 1;
        end
        if (mem_wr) begin
            wr_cnt   = wr_cnt + 1;
            wr_addr  = mem_addr;
            wr_data  = mem_wdata;
            wr_space = mem_space;
        end
        if (busy && ex_out_of_order) seen_oo = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; wake = 1'b0; inj_valid = 1'b0; inj_opcode = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fcnt = 0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic inject(input logic [7:0] op);
        @(negedge clk);
        inj_valid = 1'b1; inj_opcode = op;
        @(negedge clk);
        inj_valid = 1'b0;
        for (int i = 0; i < 20 && !inj_ready; i++) @(negedge clk);
    endtask

    task automatic run_program(input string tag);
        @(negedge clk);
        run = 1'b1;
        wait_halt(tag);
        check({tag, "_halt_hold"}, 32'(halted), 32'd1);
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin cmem[i] = 8'd0; dmem[i] = 8'd0; end
        mem_rdata = 8'd0;
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_sp", 32'(sp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_inj_ready", 32'(inj_ready), 32'd1);
        check("rst_strobes", {29'd0, mem_rd, mem_wr, |mem_space}, 32'd0);

        // "7" "3" "+" stop
        cmem[0] = 8'h37; cmem[1] = 8'h33; cmem[2] = 8'h2B; cmem[3] = 8'hFF;
        @(negedge clk);
        run = 1'b1;
        wait_halt("add_halt");
        check("add_pc", 32'(pc), 32'd4);
        check("add_sp", 32'(sp), 32'd1);
        check("add_top", 32'(ex_stack_top), 32'h6A);
        check("add_fetch_gap", 32'(ftime[1] - ftime[0]), 32'd3);
        repeat (3) @(negedge clk);
        check("halt_held_run1", 32'(halted), 32'd1);
        run = 1'b0;
        @(negedge clk);
        check("halt_exit_halted", 32'(halted), 32'd0);
        check("halt_exit_busy", 32'(busy), 32'd0);

        // Out-of-order push of "A"
        seen_oo = 1'b0;
        inject(8'h41);
        check("inj_oo_seen", 32'(seen_oo), 32'd1);
        check("inj_top", 32'(ex_stack_top), 32'h41);
        check("inj_sp", 32'(sp), 32'd2);
        check("inj_pc", 32'(pc), 32'd4);
        check("inj_idle", 32'(inj_ready), 32'd1);
        check("inj_oo_clear", 32'(ex_out_of_order), 32'd0);

        // Data write: push 5, push 0x10, "w"
        do_reset();
        inject(8'h05);
        inject(8'h10);
        wr_cnt = 0;
        inject(8'h77);
        check("w_count", 32'(wr_cnt), 32'd1);
        check("w_addr", 32'(wr_addr), 32'h10);
        check("w_data", 32'(wr_data), 32'h05);
        check("w_space", 32'(wr_space), 32'd2);
        check("w_sp", 32'(sp), 32'd0);
        check("w_dmem", 32'(dmem[8'h10]), 32'h05);

        // Delay: top=2, DELAY_CYCLES=4 -> 8 DELAY cycles between fetches
        do_reset();
        inject(8'h02);
        cmem[0] = 8'h2C; cmem[1] = 8'hFF;
        run_program("delay_halt");
        check("delay_fetch_gap", 32'(ftime[1] - ftime[0]), 32'd11);
        check("delay_pc", 32'(pc), 32'd2);
        check("delay_sp", 32'(sp), 32'd0);

        // "?" code read from address on top of stack
        do_reset();
        inject(8'h20);
        cmem[0] = 8'h3F; cmem[1] = 8'hFF; cmem[8'h20] = 8'h99;
        run_program("qread_halt");
        check("qread_top", 32'(ex_stack_top), 32'h99);
        check("qread_sp", 32'(sp), 32'd1);
        check("qread_fetch_gap", 32'(ftime[1] - ftime[0]), 32'd4);

        // Sleep held for 50 cycles then woken
        do_reset();
        cmem[0] = 8'h7A; cmem[1] = 8'hFF;
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 50 && fcnt < 1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        repeat (50) @(negedge clk);
        check("sleep_fetches", 32'(fcnt), 32'd1);
        check("sleep_busy", 32'(busy), 32'd1);
        check("sleep_pc", 32'(pc), 32'd1);
        wake = 1'b1;
        @(negedge clk);
        wake = 1'b0;
        wait_halt("sleep_halt");
        check("sleep_wake_fetch", 32'(faddr[1]), 32'd1);
        check("sleep_end_pc", 32'(pc), 32'd2);
        run = 1'b0;
        @(negedge clk);

        // Stack pointer wrap both ways
        do_reset();
        inject(8'h2B);
        check("wrap_under_sp", 32'(sp), 32'd31);
        inject(8'h42);
        check("wrap_over_sp", 32'(sp), 32'd0);
        check("wrap_top", 32'(ex_stack_top), 32'h42);

        // Reset asserted in the middle of DELAY
        do_reset();
        inject(8'h03);
        cmem[0] = 8'h2C;
        @(negedge clk);
        run = 1'b1;
        for (int i = 0; i < 50 && fcnt < 1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("mid_delay_busy", 32'(busy), 32'd1);
        check("mid_delay_pc", 32'(pc), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_strobes", {29'd0, mem_rd, mem_wr, |mem_space}, 32'd0);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
